// File: rtl/gate_lane_arbiter.sv
// Two-lane barrier gate controller: round-robin lane grant, PIN check,
// timed opening, lockout after repeated wrong codes, tailgate detection.
module gate_lane_arbiter #(
    parameter logic [7:0]  PIN          = 8'b00100110,
    parameter int unsigned MAX_TRIES    = 3,
    parameter int unsigned OPEN_TIMEOUT = 100
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] sensorA,
    input  logic       sensorB,
    input  logic [7:0] pass0,
    input  logic [7:0] pass1,
    input  logic [1:0] passValid,
    output logic [1:0] grant,
    output logic       gateState,
    output logic       wrongPinAlarm,
    output logic       blockAlarm
);

    localparam int unsigned TRIES_W = $clog2(MAX_TRIES + 1);
    localparam int unsigned TIMER_W = $clog2(OPEN_TIMEOUT);
    localparam logic [TRIES_W-1:0] TRIES_LAST = TRIES_W'(MAX_TRIES - 1);
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(OPEN_TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, WAIT_PIN, OPEN, BLOCKED} state_t;

    state_t             state, stateNext;
    logic [1:0]         grantNext;
    logic               ptr, ptrNext;
    logic [TRIES_W-1:0] tries, triesNext;
    logic [TIMER_W-1:0] timer, timerNext;
    logic               gateNext, wrongNext, blockNext;
    logic               pick;

    // Only the granted lane is observed; grant is 00 outside ownership, so lane 0 is a harmless default.
    logic       lane;
    logic       laneSensor;
    logic       laneStrobe;
    logic [7:0] laneCode;
    logic       pinOk;

    assign lane       = grant[1];
    assign laneSensor = sensorA[lane];
    assign laneStrobe = passValid[lane];
    assign laneCode   = lane ? pass1 : pass0;
    assign pinOk      = (laneCode == PIN);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            grant         <= '0;
            ptr           <= 1'b0;
            tries         <= '0;
            timer         <= '0;
            gateState     <= 1'b0;
            wrongPinAlarm <= 1'b0;
            blockAlarm    <= 1'b0;
        end else begin
            state         <= stateNext;
            grant         <= grantNext;
            ptr           <= ptrNext;
            tries         <= triesNext;
            timer         <= timerNext;
            gateState     <= gateNext;
            wrongPinAlarm <= wrongNext;
            blockAlarm    <= blockNext;
        end
    end

    always_comb begin
        stateNext = state;
        grantNext = grant;
        ptrNext   = ptr;
        triesNext = tries;
        timerNext = timer;
        gateNext  = gateState;
        wrongNext = wrongPinAlarm;
        blockNext = blockAlarm;
        pick      = 1'b0;

        case (state)
            IDLE: begin
                if (sensorA != 2'b00) begin
                    pick      = (sensorA == 2'b11) ? ptr : sensorA[1];
                    grantNext = pick ? 2'b10 : 2'b01;
                    ptrNext   = ~pick;
                    stateNext = WAIT_PIN;
                end
            end
            WAIT_PIN: begin
                if (laneStrobe) begin
                    if (pinOk) begin
                        stateNext = OPEN;
                        triesNext = '0;
                        wrongNext = 1'b0;
                        gateNext  = 1'b1;
                        timerNext = '0;
                    end else begin
                        wrongNext = 1'b1;
                        triesNext = tries + 1'b1;
                        if (tries == TRIES_LAST) begin
                            stateNext = BLOCKED;
                            blockNext = 1'b1;
                        end
                    end
                end else if (!laneSensor) begin
                    stateNext = IDLE;
                    grantNext = '0;
                    triesNext = '0;
                    wrongNext = 1'b0;
                end
            end
            OPEN: begin
                if (sensorB) begin
                    gateNext = 1'b0;
                    if (laneSensor) begin
                        stateNext = BLOCKED;
                        blockNext = 1'b1;
                    end else begin
                        stateNext = IDLE;
                        grantNext = '0;
                    end
                end else if (timer == TIMER_LAST) begin
                    stateNext = IDLE;
                    grantNext = '0;
                    gateNext  = 1'b0;
                end else begin
                    timerNext = timer + 1'b1;
                end
            end
            BLOCKED: begin
                if (laneStrobe && pinOk) begin
                    stateNext = IDLE;
                    grantNext = '0;
                    blockNext = 1'b0;
                    wrongNext = 1'b0;
                    triesNext = '0;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

endmodule

// File: tb/tb_gate_lane_arbiter.sv
// Bench for gate_lane_arbiter: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a lane-ownership model.
module tb_gate_lane_arbiter;

    localparam logic [7:0] PIN  = 8'h26;
    localparam int         MAXT = 3;
    localparam int         TOUT = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [1:0] sensorA = '0;
    logic       sensorB = 1'b0;
    logic [7:0] pass0 = '0;
    logic [7:0] pass1 = '0;
    logic [1:0] passValid = '0;
    logic [1:0] grant;
    logic       gateState, wrongPinAlarm, blockAlarm;

    int nChecks = 0;
    int nPass   = 0;

    gate_lane_arbiter #(.PIN(PIN), .MAX_TRIES(MAXT), .OPEN_TIMEOUT(TOUT)) dut (
        .clk(clk), .reset(reset), .sensorA(sensorA), .sensorB(sensorB),
        .pass0(pass0), .pass1(pass1), .passValid(passValid),
        .grant(grant), .gateState(gateState),
        .wrongPinAlarm(wrongPinAlarm), .blockAlarm(blockAlarm)
    );

    always #5 clk = ~clk;

    // Model: who owns the gate, whether it is open/locked, how long it has been open.
    int owner = -1;
    int nextPref = 0;
    int wrongs = 0;
    int openAge = 0;
    bit isOpen = 0, isLocked = 0, mWrong = 0, mBlock = 0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            owner = -1; nextPref = 0; wrongs = 0; openAge = 0;
            isOpen = 0; isLocked = 0; mWrong = 0; mBlock = 0;
        end else if (owner < 0) begin
            if (sensorA != 2'b00) begin
                owner = (sensorA == 2'b11) ? nextPref : (sensorA[1] ? 1 : 0);
                nextPref = 1 - owner;
            end
        end else begin
            bit strobe, here, ok;
            strobe = passValid[owner];
            here   = sensorA[owner];
            ok     = ((owner == 1) ? pass1 : pass0) == PIN;
            if (isLocked) begin
                if (strobe && ok) begin
                    owner = -1; isLocked = 0; mBlock = 0; mWrong = 0; wrongs = 0;
                end
            end else if (isOpen) begin
                if (sensorB) begin
                    isOpen = 0;
                    if (here) begin isLocked = 1; mBlock = 1; end
                    else owner = -1;
                end else if (openAge == TOUT) begin
                    isOpen = 0; owner = -1;
                end else begin
                    openAge++;
                end
            end else if (strobe) begin
                if (ok) begin
                    isOpen = 1; openAge = 1; wrongs = 0; mWrong = 0;
                end else begin
                    mWrong = 1; wrongs++;
                    if (wrongs == MAXT) begin isLocked = 1; mBlock = 1; end
                end
            end else if (!here) begin
                owner = -1; wrongs = 0; mWrong = 0;
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        nChecks++;
        if (act == exp) nPass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // Compare process: outputs are stable around the falling edge.
    always @(negedge clk) begin
        logic [1:0] expGrant;
        expGrant = (owner < 0) ? 2'b00 : ((owner == 1) ? 2'b10 : 2'b01);
        check("model.grant", int'(grant), int'(expGrant));
        check("model.gate", int'(gateState), int'(isOpen));
        check("model.wrongPin", int'(wrongPinAlarm), int'(mWrong));
        check("model.block", int'(blockAlarm), int'(mBlock));
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe(input int ln, input logic [7:0] code);
        passValid = (ln == 1) ? 2'b10 : 2'b01;
        if (ln == 1) pass1 = code; else pass0 = code;
    endtask

    initial begin
        reset = 1'b1;
        #12;
        check("reset.grant", int'(grant), 0);
        check("reset.gate", int'(gateState), 0);
        check("reset.alarms", int'({wrongPinAlarm, blockAlarm}), 0);
        cycle();
        reset = 1'b0;

        // Single lane, correct PIN, vehicle passes.
        sensorA = 2'b01;
        cycle();
        check("single.grant", int'(grant), 1);
        strobe(0, 8'h26);
        cycle();
        passValid = '0;
        check("single.open", int'(gateState), 1);
        sensorA = 2'b00; sensorB = 1'b1;
        cycle();
        check("single.closed", int'(gateState), 0);
        check("single.release", int'(grant), 0);
        sensorB = 1'b0;

        // Lockout on lane 1.
        sensorA = 2'b10;
        cycle();
        check("lock.grant", int'(grant), 2);
        strobe(1, 8'h00);
        cycle();
        check("lock.wrong1", int'(wrongPinAlarm), 1);
        check("lock.noblock1", int'(blockAlarm), 0);
        cycle();
        cycle();
        check("lock.block3", int'(blockAlarm), 1);
        cycle();
        passValid = '0;
        check("lock.extra", int'({grant, wrongPinAlarm, blockAlarm}), 'b1011);
        strobe(1, 8'h26);
        sensorA = 2'b00;
        cycle();
        passValid = '0;
        check("lock.cleared", int'({grant, wrongPinAlarm, blockAlarm}), 0);

        // Arbitration from reset.
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        sensorA = 2'b11;
        cycle();
        check("arb.first", int'(grant), 1);
        strobe(0, 8'h26);
        cycle();
        passValid = '0;
        sensorA = 2'b10; sensorB = 1'b1;
        cycle();
        check("arb.done0", int'(grant), 0);
        sensorA = 2'b11; sensorB = 1'b0;
        cycle();
        check("arb.second", int'(grant), 2);

        // Tailgating on lane 1.
        strobe(1, 8'h26);
        cycle();
        passValid = '0;
        check("tail.open", int'(gateState), 1);
        sensorA = 2'b10; sensorB = 1'b1;
        cycle();
        check("tail.gate", int'(gateState), 0);
        check("tail.block", int'(blockAlarm), 1);
        sensorB = 1'b0; sensorA = 2'b00;
        strobe(1, 8'h26);
        cycle();
        passValid = '0;
        check("tail.exit", int'({grant, blockAlarm}), 0);

        // Timeout: gate open for exactly TOUT cycles.
        sensorA = 2'b01;
        cycle();
        strobe(0, 8'h26);
        cycle();
        passValid = '0;
        begin
            int highCycles = 0;
            while (gateState && highCycles < 20) begin
                highCycles++;
                cycle();
            end
            check("timeout.cycles", highCycles, TOUT);
        end
        check("timeout.idle", int'(grant), 0);

        // Async reset while open; ptr must return to lane 0.
        cycle();
        strobe(0, 8'h26);
        cycle();
        passValid = '0;
        check("async.preopen", int'(gateState), 1);
        @(posedge clk);
        #3 reset = 1'b1;
        #1;
        check("async.dropped", int'({grant, gateState, wrongPinAlarm, blockAlarm}), 0);
        cycle();
        reset = 1'b0;
        sensorA = 2'b11;
        cycle();
        check("async.resume", int'(grant), 1);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(3) == 0) sensorA = 2'($urandom);
            sensorB   = ($urandom_range(5) == 0);
            passValid = {($urandom_range(3) == 0), ($urandom_range(3) == 0)};
            pass0     = $urandom_range(1) ? PIN : 8'($urandom);
            pass1     = $urandom_range(1) ? PIN : 8'($urandom);
            reset     = ($urandom_range(299) == 0);
            cycle();
        end
        reset = 1'b0;
        cycle();

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule

// File: doc/gate_lane_arbiter.md
# gate_lane_arbiter

Controller that shares a single parking barrier gate between two approach lanes, each with its own vehicle-presence sensor and PIN keypad. It grants the gate to one lane at a time with round-robin fairness, validates the lane's PIN, and opens the gate until the vehicle clears the inner sensor. It tracks failed attempts, detects tailgating, and raises wrong-PIN and block alarms. It sits between the lane sensors/keypads and the barrier actuator and alarm panel.

## Interface
- PIN, 8'b00100110, correct access code.
- MAX_TRIES, 3, wrong attempts that force BLOCKED (1..7).
- OPEN_TIMEOUT, 100, cycles the gate stays open without sensorB before auto-close (≥2).

- clk  in  1  single system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high; returns all state and outputs to reset values immediately.
- sensorA  in  2  bit i = vehicle present at lane i entrance.
- sensorB  in  1  vehicle present past the gate (shared inner sensor).
- pass0  in  8  lane 0 keypad code.
- pass1  in  8  lane 1 keypad code.
- passValid  in  2  bit i = one-cycle strobe, passi holds a submitted code.
- grant  out  2  one-hot lane currently owning the gate; 2'b00 when none.
- gateState  out  1  1 = barrier open.
- wrongPinAlarm  out  1  last submitted PIN was wrong.
- blockAlarm  out  1  lane blocked (attempts exhausted or tailgating).

## Operation
- States: IDLE, WAIT_PIN, OPEN, BLOCKED. Registers: state, grant, priority pointer ptr (1 bit), attempt counter tries (width $clog2(MAX_TRIES+1)), open-timer.
- IDLE: grant = 0, gateState = 0. If exactly one sensorA bit is set, grant that lane. If both are set, grant lane ptr. On grant, go to WAIT_PIN and set ptr to the other lane.
- Only the granted lane's sensorA, passValid and pass are observed. Other-lane inputs are ignored until the next IDLE.
- WAIT_PIN:
  - passValid[g] with pass_g == PIN: go to OPEN, tries = 0, wrongPinAlarm = 0.
  - passValid[g] with wrong code: wrongPinAlarm = 1, tries++. If tries+1 == MAX_TRIES: go to BLOCKED, blockAlarm = 1.
  - sensorA[g] == 0 with no strobe: go to IDLE, tries = 0, wrongPinAlarm = 0.
  - Strobe and sensorA drop in the same cycle: the strobe wins.
- OPEN: gateState = 1, timer counts up from 0.
  - sensorB == 1 and sensorA[g] == 0: go to IDLE (vehicle passed).
  - sensorB == 1 and sensorA[g] == 1: tailgating. Go to BLOCKED, blockAlarm = 1, gateState = 0.
  - timer reaches OPEN_TIMEOUT-1 with sensorB == 0: go to IDLE.
  - passValid strobes are ignored.
- BLOCKED: gateState = 0, grant held.
  - Only passValid[g] with the correct PIN exits: go to IDLE, blockAlarm = 0, wrongPinAlarm = 0, tries = 0.
  - Wrong codes are ignored, with no counter or alarm change.
  - Sensor changes are ignored.
- Every transition into IDLE clears grant on the same edge.

## Timing
- Reset values: state IDLE, grant 2'b00, gateState 0, wrongPinAlarm 0, blockAlarm 0, tries 0, ptr 0, timer 0.
- All outputs are registered (Moore). Each output reflects the state entered at the edge that samples the causing input, so latency is 1 cycle.
- sensorA sampled high in IDLE at edge k: grant valid after edge k. A PIN strobe is accepted from edge k+1.
- Correct strobe at edge k: gateState = 1 after edge k.
- Wrong strobe at edge k: wrongPinAlarm = 1 after edge k. The MAX_TRIES-th wrong strobe also sets blockAlarm after edge k.
- Timeout: entering OPEN at edge k with no sensorB closes the gate after edge k+OPEN_TIMEOUT.
- Reset asserted mid-operation (e.g. in OPEN): gateState, grant and alarms drop asynchronously without waiting for clk. ptr returns to 0.
- Inputs are synchronous to clk. Debouncing is done upstream.

## Test plan
- Single lane, correct PIN: sensorA = 2'b01, then passValid[0] with pass0 = 8'h26. Required: grant = 01, gateState = 1 one cycle after the strobe. Then sensorA = 0 and sensorB = 1: gateState = 0 and grant = 00 after the next edge.
- Lockout: lane 1 granted, three strobes with pass1 = 8'h00. Required: wrongPinAlarm = 1 after the first strobe, blockAlarm = 1 and state BLOCKED after the third. A further wrong code causes no change. pass1 = 8'h26 clears both alarms and returns to IDLE.
- Arbitration: sensorA = 2'b11 from reset. Required: grant = 01 first. After lane 0 completes, with both still present, grant = 10 next.
- Tailgating: in OPEN with sensorA[g] = 1 and sensorB = 1. Required: gateState = 0, blockAlarm = 1 after one edge.
- Timeout: OPEN_TIMEOUT = 4, correct PIN, no sensorB. Required: gateState high for exactly 4 cycles, then IDLE.
- Async reset: assert reset mid-cycle while gateState = 1. Required: gateState, grant and alarms become 0 before the next clk edge. Normal service resumes after reset is released.
